// File: rtl/video_pattern_gen.sv
// Parametrised raster timing generator with bars/grid/gradient/solid test patterns and a frame-start marker.
// Define VPG_SCROLL_EN to make the colour bars scroll left by one pixel per frame.
module video_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int DW       = 8,
    parameter int NUM_BARS = 8,
    parameter int GRID     = 32
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [3*DW-1:0] solid_rgb,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic [DW-1:0]   rgb_r,
    output logic [DW-1:0]   rgb_g,
    output logic [DW-1:0]   rgb_b,
    output logic            frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int X_W     = $clog2(H_ACTIVE + 1);
    localparam int G_W     = $clog2(GRID + 1);
    localparam int BW      = H_ACTIVE / NUM_BARS;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] BW_LAST  = X_W'(BW - 1);
    localparam logic [X_W-1:0] BAR_LAST = X_W'(NUM_BARS - 1);
    localparam logic [G_W-1:0] G_LAST   = G_W'(GRID - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Bar tracker: scrolled x, pixel position inside the bar, bar index.
    typedef struct packed {
        logic [X_W-1:0] xs;
        logic [X_W-1:0] pix;
        logic [X_W-1:0] idx;
    } bar_t;

    function automatic bar_t bar_step(input bar_t b);
        bar_t n;
        n = b;
        if (b.xs == X_LAST) begin
            n = '0;
        end else begin
            n.xs = b.xs + 1'b1;
            // The last bar never wraps, so it soaks up the H_ACTIVE remainder.
            if (b.idx != BAR_LAST && b.pix == BW_LAST) begin
                n.pix = '0;
                n.idx = b.idx + 1'b1;
            end else begin
                n.pix = b.pix + 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [3*DW-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return {{DW{c[2]}}, {DW{c[1]}}, {DW{c[0]}}};
    endfunction

    logic [H_W-1:0]  h_cnt, h_nx;
    logic [V_W-1:0]  v_cnt, v_nx;
    logic [G_W-1:0]  gx, gy, gx_nx, gy_nx;
    logic [1:0]      mode_q, cur_mode;
    logic [3*DW-1:0] solid_q, cur_solid, pix_rgb;
    logic            at_origin, act;
    bar_t            bar, bar_nx, bar_st, bar_fr;

`ifdef VPG_SCROLL_EN
    // bar_st: start state for the next frame; bar_fr: start state of the frame in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bar_st <= '0;
            bar_fr <= '0;
        end else if (en && at_origin) begin
            bar_fr <= bar_st;
            bar_st <= bar_step(bar_st);
        end
    end
`else
    assign bar_st = '0;
    assign bar_fr = '0;
`endif

    always_comb begin
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        cur_mode  = at_origin ? mode : mode_q;
        cur_solid = at_origin ? solid_rgb : solid_q;

        case (cur_mode)
            2'd0:    pix_rgb = bar_colour(3'(bar.idx));
            2'd1:    pix_rgb = (gx == '0 || gy == '0) ? '1 : '0;
            2'd2:    pix_rgb = {3{DW'(h_cnt)}};
            default: pix_rgb = cur_solid;
        endcase

        h_nx   = h_cnt + 1'b1;
        v_nx   = v_cnt;
        bar_nx = bar_step(bar);
        gx_nx  = (gx == G_LAST) ? '0 : gx + 1'b1;
        gy_nx  = gy;
        if (h_cnt == H_LAST) begin
            h_nx   = '0;
            gx_nx  = '0;
            v_nx   = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            gy_nx  = (v_cnt == V_LAST || gy == G_LAST) ? '0 : gy + 1'b1;
            bar_nx = (v_cnt == V_LAST) ? bar_st : bar_fr;
        end
    end

    // Output stage: everything registered, one clk behind the counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            gx          <= '0;
            gy          <= '0;
            bar         <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            frame_start <= 1'b0;
            {rgb_r, rgb_g, rgb_b} <= '0;
        end else if (!en) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            gx          <= '0;
            gy          <= '0;
            bar         <= bar_st;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            de          <= 1'b0;
            frame_start <= 1'b0;
            {rgb_r, rgb_g, rgb_b} <= '0;
        end else begin
            h_cnt       <= h_nx;
            v_cnt       <= v_nx;
            gx          <= gx_nx;
            gy          <= gy_nx;
            bar         <= bar_nx;
            if (at_origin) begin
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end
            hs          <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_ON : ~HS_ON;
            vs          <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_ON : ~VS_ON;
            de          <= act;
            frame_start <= at_origin;
            {rgb_r, rgb_g, rgb_b} <= act ? pix_rgb : '0;
        end
    end
endmodule
